// File: rtl/pu_requant_oc_serializer_if.sv
// Handshake and data bundle between the PReLU stage, the requant serializer and
// the PU write-back stage. Slave is the serializer's view; master drives it.
interface pu_requant_oc_serializer_if #(
  parameter int RELU_IN_WD = 24,
  parameter int PE_COL_NUM = 32,
  parameter int OUT_WD     = 8,
  parameter int SHIFT_WD   = 5
);
  logic                             pu_rq_vld_i;
  logic                             pu_rq_rdy_o;
  logic [RELU_IN_WD*PE_COL_NUM-1:0] prelu_oc0_i;
  logic [RELU_IN_WD*PE_COL_NUM-1:0] prelu_oc1_i;
  logic [RELU_IN_WD*PE_COL_NUM-1:0] prelu_oc2_i;
  logic [RELU_IN_WD*PE_COL_NUM-1:0] prelu_oc3_i;
  logic [SHIFT_WD-1:0]              rq_shift_i;
  logic                             pu_rq_vld_o;
  logic                             pu_rq_rdy_i;
  logic [OUT_WD*PE_COL_NUM-1:0]     rq_row_o;
  logic [1:0]                       rq_oc_idx_o;
  logic                             rq_last_o;

  modport slave (
    input  pu_rq_vld_i, prelu_oc0_i, prelu_oc1_i, prelu_oc2_i, prelu_oc3_i,
    input  rq_shift_i, pu_rq_rdy_i,
    output pu_rq_rdy_o, pu_rq_vld_o, rq_row_o, rq_oc_idx_o, rq_last_o
  );

  modport master (
    output pu_rq_vld_i, prelu_oc0_i, prelu_oc1_i, prelu_oc2_i, prelu_oc3_i,
    output rq_shift_i, pu_rq_rdy_i,
    input  pu_rq_rdy_o, pu_rq_vld_o, rq_row_o, rq_oc_idx_o, rq_last_o
  );
endinterface

// File: rtl/pu_requant_oc_serializer.sv
// Requantizes a 4-OC beat of PReLU results (round-half-up shift + saturation)
// and emits it as 4 consecutive single-OC rows for the PU write-back stage.
module pu_requant_oc_serializer #(
  parameter int RELU_IN_WD = 24,
  parameter int PE_COL_NUM = 32,
  parameter int OUT_WD     = 8,
  parameter int SHIFT_WD   = 5
) (
  input  logic clk,
  input  logic rst,
  pu_requant_oc_serializer_if.slave rq_bus
);

  localparam int ROW_IN_W  = RELU_IN_WD * PE_COL_NUM;
  localparam int ROW_OUT_W = OUT_WD * PE_COL_NUM;

  localparam logic signed [RELU_IN_WD:0] WIDE_ONE = {{RELU_IN_WD{1'b0}}, 1'b1};
  localparam logic signed [RELU_IN_WD:0] SAT_MAX  =
    {{(RELU_IN_WD-OUT_WD+2){1'b0}}, {(OUT_WD-1){1'b1}}};
  localparam logic signed [RELU_IN_WD:0] SAT_MIN  =
    {{(RELU_IN_WD-OUT_WD+2){1'b1}}, {(OUT_WD-1){1'b0}}};
  localparam logic [SHIFT_WD:0] SHIFT_LIMIT = (SHIFT_WD+1)'(RELU_IN_WD);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [1:0]            oc_cnt_q, oc_cnt_d;
  logic [ROW_IN_W-1:0]   row_q [4];
  logic [SHIFT_WD-1:0]   shift_q;

  logic                  rdy_out;
  logic                  accept;
  logic                  last_row;
  logic [ROW_IN_W-1:0]   sel_row;
  logic [ROW_OUT_W-1:0]  row_out;

  // One extra MSB keeps x + rounding constant from wrapping at max positive.
  // Out-of-range shifts collapse to the sign fill of x instead of relying on
  // shift-operator behaviour past the word width.
  function automatic logic signed [RELU_IN_WD:0] round_shift(
    input logic signed [RELU_IN_WD-1:0] x,
    input logic        [SHIFT_WD-1:0]   s
  );
    logic signed [RELU_IN_WD:0] rnd;
    logic signed [RELU_IN_WD:0] t;
    rnd = '0;
    if ({1'b0, s} >= SHIFT_LIMIT) begin
      return {(RELU_IN_WD+1){x[RELU_IN_WD-1]}};
    end
    if (s != '0) begin
      rnd = WIDE_ONE <<< (s - SHIFT_WD'(1));
    end
    t = {x[RELU_IN_WD-1], x} + rnd;
    return t >>> s;
  endfunction

  function automatic logic signed [OUT_WD-1:0] saturate(
    input logic signed [RELU_IN_WD:0] y
  );
    if (y > SAT_MAX) begin
      return SAT_MAX[OUT_WD-1:0];
    end
    if (y < SAT_MIN) begin
      return SAT_MIN[OUT_WD-1:0];
    end
    return y[OUT_WD-1:0];
  endfunction

  assign last_row = (oc_cnt_q == 2'd3);
  // The final row's handshake frees the buffer in the same cycle, so a new
  // beat can be taken with no bubble between beats.
  assign rdy_out  = (state_q == IDLE) ||
                    ((state_q == SEND) && last_row && rq_bus.pu_rq_rdy_i);
  assign accept   = rq_bus.pu_rq_vld_i && rdy_out;

  always_comb begin
    state_d  = state_q;
    oc_cnt_d = oc_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SEND;
          oc_cnt_d = 2'd0;
        end
      end
      SEND: begin
        if (rq_bus.pu_rq_rdy_i) begin
          if (last_row) begin
            state_d  = accept ? SEND : IDLE;
            oc_cnt_d = 2'd0;
          end else begin
            oc_cnt_d = oc_cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        oc_cnt_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      oc_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      oc_cnt_q <= oc_cnt_d;
    end
  end

  // Beat buffer: loads only on accept, cleared by reset so a discarded beat
  // can never leak onto rq_row_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        row_q[i] <= '0;
      end
      shift_q <= '0;
    end else if (accept) begin
      row_q[0] <= rq_bus.prelu_oc0_i;
      row_q[1] <= rq_bus.prelu_oc1_i;
      row_q[2] <= rq_bus.prelu_oc2_i;
      row_q[3] <= rq_bus.prelu_oc3_i;
      shift_q  <= rq_bus.rq_shift_i;
    end
  end

  always_comb begin
    sel_row = row_q[oc_cnt_q];
    row_out = '0;
    for (int l = 0; l < PE_COL_NUM; l++) begin
      row_out[(PE_COL_NUM-1-l)*OUT_WD +: OUT_WD] =
        saturate(round_shift(sel_row[(PE_COL_NUM-1-l)*RELU_IN_WD +: RELU_IN_WD], shift_q));
    end
  end

  assign rq_bus.pu_rq_rdy_o = rdy_out;
  assign rq_bus.pu_rq_vld_o = (state_q == SEND);
  assign rq_bus.rq_oc_idx_o = oc_cnt_q;
  assign rq_bus.rq_last_o   = (state_q == SEND) && last_row;
  assign rq_bus.rq_row_o    = row_out;

endmodule
